// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Purpose  : Stall/flush sequencer for the 5-stage RV64 pipeline (load-use,
//            branch squash, data-memory freeze). Optional perf counters are
//            built when PERF_COUNTERS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
   parameter int LU_BUBBLES = 1,
   parameter int REG_AW     = 5,
   parameter int CNT_W      = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_uses_rs2,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_mem_read,
   input  logic              ex_branch_taken,
   input  logic              mem_req,
   input  logic              mem_ready,
   output logic              pc_write,
   output logic              ifid_write,
   output logic              ifid_flush,
   output logic              idex_bubble,
   output logic              idex_flush,
   output logic              pipe_freeze,
   output logic              stall,
   output logic              flush,
   output logic [CNT_W-1:0]  stall_cycles,
   output logic [CNT_W-1:0]  flush_events
);

   localparam logic [1:0] c_st_run   = 2'd0;
   localparam logic [1:0] c_st_lu    = 2'd1;
   localparam logic [1:0] c_st_mem   = 2'd2;

   localparam logic [1:0] c_md_norm  = 2'd0;
   localparam logic [1:0] c_md_stall = 2'd1;
   localparam logic [1:0] c_md_flush = 2'd2;
   localparam logic [1:0] c_md_frz   = 2'd3;

   localparam logic [1:0] c_lu_init  = 2'(LU_BUBBLES - 1);

   logic [1:0] r_state;
   logic [1:0] r_saved;
   logic [1:0] r_lu_cnt;
   logic [1:0] w_state_nxt;
   logic [1:0] w_saved_nxt;
   logic [1:0] w_lu_cnt_nxt;
   logic [1:0] w_eff;
   logic [1:0] w_mode;
   logic       w_hazard;
   logic       w_mem_busy;

   assign w_hazard = ex_mem_read && (ex_rd != '0) &&
                     ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
   assign w_mem_busy = mem_req && !mem_ready;

   // In the mem_ready cycle the frozen state is already thawed and behaves as
   // the state saved on entry, so a held branch or pending stall acts at once.
   assign w_eff = ((r_state == c_st_mem) && mem_ready) ? r_saved : r_state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= c_st_run;
         r_saved  <= c_st_run;
         r_lu_cnt <= 2'd0;
      end else begin
         r_state  <= w_state_nxt;
         r_saved  <= w_saved_nxt;
         r_lu_cnt <= w_lu_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_saved_nxt  = r_saved;
      w_lu_cnt_nxt = r_lu_cnt;
      w_mode       = c_md_norm;
      if ((r_state == c_st_mem) && !mem_ready) begin
         w_mode = c_md_frz;
      end else begin
         case (w_eff)
            c_st_run: begin
               w_state_nxt = c_st_run;
               if (w_mem_busy) begin
                  w_mode      = c_md_frz;
                  w_state_nxt = c_st_mem;
                  w_saved_nxt = c_st_run;
               end else if (ex_branch_taken) begin
                  w_mode = c_md_flush;
               end else if (w_hazard) begin
                  w_mode       = c_md_stall;
                  w_lu_cnt_nxt = c_lu_init;
                  w_state_nxt  = (c_lu_init != 2'd0) ? c_st_lu : c_st_run;
               end
            end
            c_st_lu: begin
               if (w_mem_busy) begin
                  w_mode      = c_md_frz;
                  w_state_nxt = c_st_mem;
                  w_saved_nxt = c_st_lu;
               end else if (ex_branch_taken) begin
                  w_mode       = c_md_flush;
                  w_lu_cnt_nxt = 2'd0;
                  w_state_nxt  = c_st_run;
               end else begin
                  w_mode       = c_md_stall;
                  w_lu_cnt_nxt = r_lu_cnt - 2'd1;
                  w_state_nxt  = (r_lu_cnt <= 2'd1) ? c_st_run : c_st_lu;
               end
            end
            default: begin
               w_state_nxt  = c_st_run;
               w_lu_cnt_nxt = 2'd0;
            end
         endcase
      end
   end

   always_comb begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      idex_flush  = 1'b0;
      pipe_freeze = 1'b0;
      stall       = 1'b0;
      flush       = 1'b0;
      if (reset) begin
         case (w_mode)
            c_md_frz: begin
               pipe_freeze = 1'b1;
               stall       = 1'b1;
            end
            c_md_flush: begin
               pc_write   = 1'b1;
               ifid_write = 1'b1;
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
               flush      = 1'b1;
            end
            c_md_stall: begin
               idex_bubble = 1'b1;
               stall       = 1'b1;
            end
            default: begin
               pc_write   = 1'b1;
               ifid_write = 1'b1;
            end
         endcase
      end
   end

`ifdef PERF_COUNTERS_EN
   logic [CNT_W-1:0] r_stall_cycles;
   logic [CNT_W-1:0] r_flush_events;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stall_cycles <= '0;
         r_flush_events <= '0;
      end else begin
         if (stall && (r_stall_cycles != '1))
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
         if (flush && (r_flush_events != '1))
            r_flush_events <= r_flush_events + CNT_W'(1);
      end
   end

   assign stall_cycles = r_stall_cycles;
   assign flush_events = r_flush_events;
`else
   assign stall_cycles = '0;
   assign flush_events = '0;
`endif

endmodule
`default_nettype wire
